tdm_demux: RTL and testbench
============================

# tdm_demux

Receive-side time-division demultiplexer for the MUX project. It accepts the byte-serial, slot-interleaved stream that the transmit-side multiplexer produces, locks to the frame-sync marker and steers each slot into a per-channel holding register. Each channel register has its own valid/ack handshake. The block sits behind the `uio_in` input path and feeds channel consumers inside the top-level `tt_um_*` wrapper.

## Interface
Parameters:
- `NUM_CH`, default 4: channels per frame (slots 0..NUM_CH-1); legal values are 2..8.
- `DATA_W`, default 8: width of each slot word.

Ports:
- `clk` in 1: the single clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `din` in DATA_W: incoming slot word.
- `din_valid` in 1: `din` is valid this cycle.
- `frame_sync` in 1: qualified by `din_valid`; marks the current word as slot 0.
- `din_par` in 1: odd-parity bit over `din`. Used only when `TDM_DEMUX_PARITY_EN` is defined.
- `ch_data` out NUM_CH*DATA_W: channel holding registers; channel i occupies bits [i*DATA_W +: DATA_W].
- `ch_valid` out NUM_CH: channel i holds unconsumed data.
- `ch_ack` in NUM_CH: consumer ack; clears `ch_valid[i]`.
- `ch_overrun` out NUM_CH: sticky flag; channel i was overwritten while its data was still unconsumed.
- `locked` out 1: the block is in state LOCKED.
- `sync_err` out 1: one-cycle pulse on a frame-alignment error.
- `frame_cnt` out 8: count of completed frames; wraps modulo 256.
- `par_err_cnt` out 8: count of parity-failed words; saturates at 255.

## Operation
- State machine:
  - In HUNT:
    - `din_valid` with `frame_sync` writes slot 0, sets `slot_cnt`=1 and moves to LOCKED.
    - `din_valid` without `frame_sync` drops the word.
  - In LOCKED with `din_valid`:
    - `slot_cnt`=0 and `frame_sync`=1: normal case. Write slot 0 and set `slot_cnt`=1.
    - `slot_cnt`≠0 and `frame_sync`=0: write slot `slot_cnt` and increment `slot_cnt`. Writing slot NUM_CH-1 wraps `slot_cnt` to 0 and increments `frame_cnt`.
    - `slot_cnt`≠0 and `frame_sync`=1: early sync. Pulse `sync_err`, write the word to slot 0, set `slot_cnt`=1, stay LOCKED. The partial frame is not counted.
    - `slot_cnt`=0 and `frame_sync`=0: missing sync. Pulse `sync_err`, drop the word and go to HUNT.
- `frame_sync` without `din_valid` is ignored in every state.
- Slot write to channel i:
  - `ch_data[i]` is loaded with `din` and `ch_valid[i]` is set to 1.
  - If `ch_valid[i]` was already 1 and `ch_ack[i]`=0 in the same cycle, set `ch_overrun[i]`. The new data still replaces the old.
- Ack:
  - `ch_ack[i]`=1 clears `ch_valid[i]` and `ch_overrun[i]` unless a write to channel i happens in the same cycle.
  - Write and ack to the same channel in one cycle: the result is `ch_valid[i]`=1, overrun not set, old overrun cleared.
  - `ch_ack[i]` while `ch_valid[i]`=0 has no effect.
- `ch_data` holds its value until the next write. Ack does not clear it.

## Timing
- Reset values:
  - State HUNT, `slot_cnt`=0.
  - `ch_data`=0, `ch_valid`=0, `ch_overrun`=0.
  - `locked`=0, `sync_err`=0, `frame_cnt`=0, `par_err_cnt`=0.
- Latency is one cycle. A word accepted on edge N appears in `ch_data`/`ch_valid` after edge N; a consumer can ack it on the following edge.
- `locked` goes high the cycle after the first sync word is accepted. It goes low the cycle after a missing-sync error.
- `sync_err` is high for exactly one cycle per error, registered with the same latency as data.
- `frame_cnt` updates on the same edge as the write to slot NUM_CH-1.
- `rst` asserted mid-frame overrides all inputs on that edge. No partial state survives reset.
- The block accepts one word per cycle (continuous `din_valid`=1) with no back-pressure. Consumers must ack in time or overruns are flagged.

## Configuration
- `TDM_DEMUX_PARITY_EN` defined:
  - Each `din_valid` word is checked for odd parity over {`din`,`din_par`}.
  - A failing word is dropped: no channel write, `slot_cnt` still advances as if written, `frame_cnt` still updates.
  - `par_err_cnt` increments on each failing word and saturates at 255.
  - Sync checking still applies to dropped words.
- Not defined: `din_par` is ignored and `par_err_cnt` is tied to 0.

## Test plan
- Reset, then NUM_CH=4 with words A0 (sync), A1, A2, A3 on consecutive cycles -> `ch_data` = {A3,A2,A1,A0}, `ch_valid`=4'b1111, `frame_cnt`=1, `locked`=1 after the first word.
- Words 0x11, 0x22 without sync in HUNT, then 0x33 with sync -> only `ch_data[0]`=0x33, `ch_valid`=4'b0001.
- Locked; sync arrives at slot 2 with data 0x5A -> `sync_err` pulses once, `ch_data[0]`=0x5A, next word goes to slot 1, `frame_cnt` unchanged.
- Complete frame 0x01..0x04, then missing sync at slot 0 -> `sync_err` pulse, `locked`=0, word dropped.
- Two full frames with no acks -> `ch_overrun`=4'b1111. Then `ch_ack`=4'b0001 -> `ch_valid`=4'b1110, `ch_overrun`=4'b1110. Same-cycle write and ack on ch1 -> `ch_valid[1]`=1, `ch_overrun[1]`=0.
- With `TDM_DEMUX_PARITY_EN`: `din`=0x03 with `din_par`=0 (even, bad) on slot 1 -> `ch_valid[1]` not set, `par_err_cnt`=1, slot 2 is still written by the next word. Reset mid-frame -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/tdm_demux.sv
// Receive-side TDM demultiplexer: locks to frame_sync and steers each slot word into a per-channel register with valid/ack.
// Optional odd-parity checking is compiled in when TDM_DEMUX_PARITY_EN is defined.
module tdm_demux #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_W-1:0]        din,
   input  logic                     din_valid,
   input  logic                     frame_sync,
   input  logic                     din_par,
   output logic [NUM_CH*DATA_W-1:0] ch_data,
   output logic [NUM_CH-1:0]        ch_valid,
   input  logic [NUM_CH-1:0]        ch_ack,
   output logic [NUM_CH-1:0]        ch_overrun,
   output logic                     locked,
   output logic                     sync_err,
   output logic [7:0]               frame_cnt,
   output logic [7:0]               par_err_cnt
);

   localparam int SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic {HUNT, LOCKED} state_t;

   state_t                    r_state, w_state_nxt;
   logic [SLOT_W-1:0]         r_slot_cnt, w_slot_nxt, w_wr_slot;
   logic                      w_accept, w_wr_en, w_sync_err, w_frame_inc, w_par_ok;
   logic [NUM_CH-1:0]         w_wr_vec;
   logic [NUM_CH*DATA_W-1:0]  r_ch_data;
   logic [NUM_CH-1:0]         r_ch_valid, r_ch_overrun;
   logic                      r_sync_err;
   logic [7:0]                r_frame_cnt;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

`ifdef TDM_DEMUX_PARITY_EN
   logic [7:0] r_par_err_cnt;

   // {din, din_par} must carry an odd number of ones
   assign w_par_ok = ^{din, din_par};

   always_ff @(posedge clk) begin
      if (rst)
         r_par_err_cnt <= 8'd0;
      else if (din_valid && !w_par_ok)
         r_par_err_cnt <= sat_inc8(r_par_err_cnt);
   end

   assign par_err_cnt = r_par_err_cnt;
`else
   logic w_unused_par;

   assign w_unused_par = din_par;
   assign w_par_ok     = 1'b1;
   assign par_err_cnt  = 8'd0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= HUNT;
         r_slot_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_slot_cnt <= w_slot_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_slot_nxt  = r_slot_cnt;
      w_wr_slot   = '0;
      w_accept    = 1'b0;
      w_sync_err  = 1'b0;
      w_frame_inc = 1'b0;
      if (din_valid) begin
         case (r_state)
            HUNT: begin
               if (frame_sync) begin
                  w_state_nxt = LOCKED;
                  w_slot_nxt  = SLOT_W'(1);
                  w_accept    = 1'b1;
               end
            end
            LOCKED: begin
               if (frame_sync) begin
                  // early sync restarts the frame at slot 0; partial frame is not counted
                  w_sync_err = (r_slot_cnt != '0);
                  w_slot_nxt = SLOT_W'(1);
                  w_accept   = 1'b1;
               end else if (r_slot_cnt == '0) begin
                  w_sync_err  = 1'b1;
                  w_state_nxt = HUNT;
               end else begin
                  w_wr_slot = r_slot_cnt;
                  w_accept  = 1'b1;
                  if (r_slot_cnt == SLOT_W'(NUM_CH - 1)) begin
                     w_slot_nxt  = '0;
                     w_frame_inc = 1'b1;
                  end else begin
                     w_slot_nxt = r_slot_cnt + SLOT_W'(1);
                  end
               end
            end
            default: w_state_nxt = HUNT;
         endcase
      end
      w_wr_en = w_accept && w_par_ok;
      for (int i = 0; i < NUM_CH; i++)
         w_wr_vec[i] = w_wr_en && (w_wr_slot == SLOT_W'(i));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ch_data    <= '0;
         r_ch_valid   <= '0;
         r_ch_overrun <= '0;
         r_sync_err   <= 1'b0;
         r_frame_cnt  <= 8'd0;
      end else begin
         r_sync_err <= w_sync_err;
         if (w_frame_inc)
            r_frame_cnt <= r_frame_cnt + 8'd1;
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_wr_vec[i]) begin
               // a same-cycle ack consumes the old word, so it is not an overrun
               r_ch_data[i*DATA_W +: DATA_W] <= din;
               r_ch_valid[i]                 <= 1'b1;
               if (ch_ack[i])
                  r_ch_overrun[i] <= 1'b0;
               else if (r_ch_valid[i])
                  r_ch_overrun[i] <= 1'b1;
            end else if (ch_ack[i] && r_ch_valid[i]) begin
               r_ch_valid[i]   <= 1'b0;
               r_ch_overrun[i] <= 1'b0;
            end
         end
      end
   end

   assign ch_data    = r_ch_data;
   assign ch_valid   = r_ch_valid;
   assign ch_overrun = r_ch_overrun;
   assign locked     = (r_state == LOCKED);
   assign sync_err   = r_sync_err;
   assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed, table-driven bench for tdm_demux (NUM_CH=4, DATA_W=8), with a few multi-cycle sequences.
module tb_tdm_demux;

`ifdef TDM_DEMUX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, din_valid, frame_sync, din_par;
   logic [7:0]  din;
   logic [31:0] ch_data;
   logic [3:0]  ch_valid, ch_ack, ch_overrun;
   logic        locked, sync_err;
   logic [7:0]  frame_cnt, par_err_cnt;

   int n_checks = 0;
   int n_errors = 0;

   tdm_demux #(.NUM_CH(4), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .frame_sync(frame_sync), .din_par(din_par), .ch_data(ch_data),
      .ch_valid(ch_valid), .ch_ack(ch_ack), .ch_overrun(ch_overrun),
      .locked(locked), .sync_err(sync_err), .frame_cnt(frame_cnt),
      .par_err_cnt(par_err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, vld, sync, par;
      logic [7:0]  din;
      logic [3:0]  ack;
      logic [31:0] e_data;
      logic [3:0]  e_valid, e_ovr;
      logic        e_lock, e_serr;
      logic [7:0]  e_frame, e_perr;
   } vec_t;

   vec_t vq[$];

   // bad=1 gives even parity over {din,din_par}
   function automatic void add(logic r, logic v, logic s, logic [7:0] d, logic bad,
                               logic [3:0] a, logic [31:0] ed, logic [3:0] ev,
                               logic [3:0] eo, logic el, logic es, logic [7:0] ef,
                               logic [7:0] ep);
      vec_t t;
      t.rst = r; t.vld = v; t.sync = s; t.din = d;
      t.par = bad ? ^d : ~^d;
      t.ack = a; t.e_data = ed; t.e_valid = ev; t.e_ovr = eo;
      t.e_lock = el; t.e_serr = es; t.e_frame = ef; t.e_perr = ep;
      vq.push_back(t);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic v, input logic s, input logic [7:0] d,
                        input logic p, input logic [3:0] a);
      @(negedge clk);
      rst = r; din_valid = v; frame_sync = s; din = d; din_par = p; ch_ack = a;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; din_valid = 1'b0; frame_sync = 1'b0; din = 8'h00; din_par = 1'b0;
      ch_ack = 4'h0;

      // reset state and full frame A0..A3
      add(1,0,0,8'h00,0,4'h0, 32'h00000000,4'b0000,4'b0000,0,0,8'd0,8'd0);
      add(0,1,1,8'hA0,0,4'h0, 32'h000000A0,4'b0001,4'b0000,1,0,8'd0,8'd0);
      add(0,1,0,8'hA1,0,4'h0, 32'h0000A1A0,4'b0011,4'b0000,1,0,8'd0,8'd0);
      add(0,1,0,8'hA2,0,4'h0, 32'h00A2A1A0,4'b0111,4'b0000,1,0,8'd0,8'd0);
      add(0,1,0,8'hA3,0,4'h0, 32'hA3A2A1A0,4'b1111,4'b0000,1,0,8'd1,8'd0);
      // reset overrides a sync word on the same edge
      add(1,1,1,8'h77,0,4'h0, 32'h00000000,4'b0000,4'b0000,0,0,8'd0,8'd0);
      // hunt: unsynced words dropped, sync without valid ignored
      add(0,1,0,8'h11,0,4'h0, 32'h00000000,4'b0000,4'b0000,0,0,8'd0,8'd0);
      add(0,1,0,8'h22,0,4'h0, 32'h00000000,4'b0000,4'b0000,0,0,8'd0,8'd0);
      add(0,0,1,8'h44,0,4'h0, 32'h00000000,4'b0000,4'b0000,0,0,8'd0,8'd0);
      add(0,1,1,8'h33,0,4'h0, 32'h00000033,4'b0001,4'b0000,1,0,8'd0,8'd0);
      // early sync at slot 2
      add(0,1,0,8'h44,0,4'h0, 32'h00004433,4'b0011,4'b0000,1,0,8'd0,8'd0);
      add(0,1,1,8'h5A,0,4'h0, 32'h0000445A,4'b0011,4'b0001,1,1,8'd0,8'd0);
      add(0,1,0,8'h66,0,4'h0, 32'h0000665A,4'b0011,4'b0011,1,0,8'd0,8'd0);
      add(0,1,0,8'h77,0,4'h0, 32'h0077665A,4'b0111,4'b0011,1,0,8'd0,8'd0);
      add(0,1,0,8'h88,0,4'h0, 32'h8877665A,4'b1111,4'b0011,1,0,8'd1,8'd0);
      // missing sync after a complete frame
      add(1,0,0,8'h00,0,4'h0, 32'h00000000,4'b0000,4'b0000,0,0,8'd0,8'd0);
      add(0,1,1,8'h01,0,4'h0, 32'h00000001,4'b0001,4'b0000,1,0,8'd0,8'd0);
      add(0,1,0,8'h02,0,4'h0, 32'h00000201,4'b0011,4'b0000,1,0,8'd0,8'd0);
      add(0,1,0,8'h03,0,4'h0, 32'h00030201,4'b0111,4'b0000,1,0,8'd0,8'd0);
      add(0,1,0,8'h04,0,4'h0, 32'h04030201,4'b1111,4'b0000,1,0,8'd1,8'd0);
      add(0,1,0,8'h99,0,4'h0, 32'h04030201,4'b1111,4'b0000,0,1,8'd1,8'd0);
      add(0,0,0,8'h00,0,4'h0, 32'h04030201,4'b1111,4'b0000,0,0,8'd1,8'd0);
      // ack clears valid but holds data; ack on empty channel does nothing
      add(0,0,0,8'h00,0,4'hF, 32'h04030201,4'b0000,4'b0000,0,0,8'd1,8'd0);
      add(0,0,0,8'h00,0,4'hF, 32'h04030201,4'b0000,4'b0000,0,0,8'd1,8'd0);
      // overrun after two frames without acks
      add(1,0,0,8'h00,0,4'h0, 32'h00000000,4'b0000,4'b0000,0,0,8'd0,8'd0);
      add(0,1,1,8'h01,0,4'h0, 32'h00000001,4'b0001,4'b0000,1,0,8'd0,8'd0);
      add(0,1,0,8'h02,0,4'h0, 32'h00000201,4'b0011,4'b0000,1,0,8'd0,8'd0);
      add(0,1,0,8'h03,0,4'h0, 32'h00030201,4'b0111,4'b0000,1,0,8'd0,8'd0);
      add(0,1,0,8'h04,0,4'h0, 32'h04030201,4'b1111,4'b0000,1,0,8'd1,8'd0);
      add(0,1,1,8'h11,0,4'h0, 32'h04030211,4'b1111,4'b0001,1,0,8'd1,8'd0);
      add(0,1,0,8'h12,0,4'h0, 32'h04031211,4'b1111,4'b0011,1,0,8'd1,8'd0);
      add(0,1,0,8'h13,0,4'h0, 32'h04131211,4'b1111,4'b0111,1,0,8'd1,8'd0);
      add(0,1,0,8'h14,0,4'h0, 32'h14131211,4'b1111,4'b1111,1,0,8'd2,8'd0);
      add(0,0,0,8'h00,0,4'h1, 32'h14131211,4'b1110,4'b1110,1,0,8'd2,8'd0);
      add(0,1,1,8'h21,0,4'h0, 32'h14131221,4'b1111,4'b1110,1,0,8'd2,8'd0);
      add(0,1,0,8'h22,0,4'h2, 32'h14132221,4'b1111,4'b1100,1,0,8'd2,8'd0);
      // parity: bad word on slot 1 (dropped only when checking is compiled in)
      add(1,0,0,8'h00,0,4'h0, 32'h00000000,4'b0000,4'b0000,0,0,8'd0,8'd0);
      add(0,1,1,8'h01,0,4'h0, 32'h00000001,4'b0001,4'b0000,1,0,8'd0,8'd0);
      add(0,1,0,8'h03,1,4'h0, PAR_EN ? 32'h00000001 : 32'h00000301,
          PAR_EN ? 4'b0001 : 4'b0011, 4'b0000,1,0,8'd0, PAR_EN ? 8'd1 : 8'd0);
      add(0,1,0,8'h05,0,4'h0, PAR_EN ? 32'h00050001 : 32'h00050301,
          PAR_EN ? 4'b0101 : 4'b0111, 4'b0000,1,0,8'd0, PAR_EN ? 8'd1 : 8'd0);
      add(0,1,0,8'h07,0,4'h0, PAR_EN ? 32'h07050001 : 32'h07050301,
          PAR_EN ? 4'b1101 : 4'b1111, 4'b0000,1,0,8'd1, PAR_EN ? 8'd1 : 8'd0);
      // mid-frame reset clears everything
      add(0,1,1,8'hC0,0,4'h0, PAR_EN ? 32'h070500C0 : 32'h070503C0,
          PAR_EN ? 4'b1101 : 4'b1111, 4'b0001,1,0,8'd1, PAR_EN ? 8'd1 : 8'd0);
      add(1,1,0,8'hC1,0,4'h0, 32'h00000000,4'b0000,4'b0000,0,0,8'd0,8'd0);

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].rst, vq[i].vld, vq[i].sync, vq[i].din, vq[i].par, vq[i].ack);
         check($sformatf("v%0d ch_data", i),     ch_data,            vq[i].e_data);
         check($sformatf("v%0d ch_valid", i),    {28'd0, ch_valid},   {28'd0, vq[i].e_valid});
         check($sformatf("v%0d ch_overrun", i),  {28'd0, ch_overrun}, {28'd0, vq[i].e_ovr});
         check($sformatf("v%0d locked", i),      {31'd0, locked},     {31'd0, vq[i].e_lock});
         check($sformatf("v%0d sync_err", i),    {31'd0, sync_err},   {31'd0, vq[i].e_serr});
         check($sformatf("v%0d frame_cnt", i),   {24'd0, frame_cnt},  {24'd0, vq[i].e_frame});
         check($sformatf("v%0d par_err_cnt", i), {24'd0, par_err_cnt},{24'd0, vq[i].e_perr});
      end

      // continuous stream with each channel acked the cycle after its write
      drive(1, 0, 0, 8'h00, 1'b0, 4'h0);
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < 4; k++) begin
            logic [7:0] w;
            w = 8'(f * 16 + k + 1);
            drive(0, 1, k == 0, w, ~^w, (f == 0 && k == 0) ? 4'h0 : 4'(1 << ((k + 3) % 4)));
            check($sformatf("stream f%0d k%0d ch_overrun", f, k), {28'd0, ch_overrun}, 32'd0);
            check($sformatf("stream f%0d k%0d sync_err", f, k), {31'd0, sync_err}, 32'd0);
         end
      end
      drive(0, 0, 0, 8'h00, 1'b0, 4'h8);
      check("stream ch_valid", {28'd0, ch_valid}, 32'd0);
      check("stream ch_data", ch_data, 32'h14131211);
      check("stream frame_cnt", {24'd0, frame_cnt}, 32'd2);

      // frame counter wraps modulo 256
      drive(1, 0, 0, 8'h00, 1'b0, 4'h0);
      for (int f = 0; f < 257; f++)
         for (int k = 0; k < 4; k++)
            drive(0, 1, k == 0, 8'h00, 1'b1, 4'hF);
      check("wrap frame_cnt", {24'd0, frame_cnt}, 32'd1);
      check("wrap locked", {31'd0, locked}, 32'd1);

      // parity error counter saturates (tied to zero without parity checking)
      drive(1, 0, 0, 8'h00, 1'b0, 4'h0);
      for (int n = 0; n < 260; n++)
         drive(0, 1, 0, 8'h03, 1'b0, 4'h0);
      check("sat par_err_cnt", {24'd0, par_err_cnt}, PAR_EN ? 32'd255 : 32'd0);
      check("sat locked", {31'd0, locked}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
